load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencing stage between the core's execute/memory stage and `data_memory`. It accepts one load or store request per transaction over a valid/ready handshake and drives the `data_memory` port signals (`mem_read`, `mem_write`, `addr`, `fun3`, `data_in`). It returns sign- or zero-extended load data to the core. Misaligned halfword and word accesses are optionally split into serial byte accesses.

## Interface
- `ADDR_W`, default 32: width of the request address and the memory address.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: core request valid.
- `req_ready` output 1: LSU can accept a request; high only in IDLE.
- `req_write` input 1: 1 = store, 0 = load.
- `req_fun3` input 3: RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010).
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: one-cycle pulse that completes the transaction.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: valid with `resp_valid`; illegal funct3, or misaligned access with splitting compiled out.
- `mem_read`, `mem_write` output 1 each: memory strobes; never both high.
- `mem_addr` output ADDR_W: drives `data_memory.addr`.
- `mem_fun3` output 3: drives `data_memory.fun3`, same funct3 encoding.
- `mem_wdata` output 32: drives `data_memory.data_in`.
- `mem_rdata` input 32: from `data_memory.data_out`; valid combinationally in the cycle `mem_read` is high. Memory writes commit on the rising edge that ends a `mem_write` cycle.

## Operation
- States: IDLE, ACCESS, SPLIT, RESP.
- **IDLE:** `req_ready=1`. On `req_valid`, register write, fun3, addr and wdata, then decode:
  - illegal funct3 (load 011/110/111, store ≥011) → RESP with error;
  - aligned (byte; half with addr[0]=0; word with addr[1:0]=0) → ACCESS;
  - misaligned → SPLIT if `LSU_MISALIGN_EN`, otherwise RESP with error.
- **ACCESS:** one memory cycle with the registered fun3 and address. Loads capture `mem_rdata` raw. → RESP.
- **SPLIT:** byte counter k=0..N-1, where N=2 (half) or 4 (word); one byte per cycle.
  - `mem_addr = addr + k`, modulo 2^ADDR_W (wraps at top of space).
  - Stores use `mem_fun3=SB` and `mem_wdata = {24'b0, wdata[8k+7:8k]}`.
  - Loads use `mem_fun3=LBU`; `mem_rdata[7:0]` is placed into byte lane k of the assembly register.
  - After k=N-1 → RESP.
- **RESP:**
  - `resp_valid=1` for exactly one cycle.
  - `resp_rdata` = assembled/captured value extended per fun3: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - → IDLE.
- Memory strobes are high only in ACCESS and SPLIT. `mem_addr`, `mem_fun3` and `mem_wdata` hold 0 outside those states.
- Reset, at any time:
  - state IDLE; all outputs 0 except `req_ready`, which is 1 after reset is released;
  - an in-flight access is abandoned and no response is issued;
  - bytes already written by SPLIT remain in memory.

## Timing
- Request accepted on edge E.
- Aligned access: memory cycle E..E+1; `resp_valid` in cycle E+1..E+2. Two-cycle latency, a new request can be accepted every 3 cycles.
- Split access: N memory cycles, then the RESP cycle. Latency N+1.
- Error: RESP in the cycle after acceptance; no memory cycle occurs.
- `req_ready` is low from acceptance until RESP exits. Requests presented while not ready are ignored; the core holds them.
- `resp_rdata` and `resp_err` are registered and stable throughout the `resp_valid` cycle.

## Configuration
- `LSU_MISALIGN_EN` defined: the SPLIT state and byte counter are compiled in; misaligned halves and words complete normally.
- Not defined: SPLIT is absent; misaligned accesses return `resp_err=1`, `resp_rdata=0`, and produce no memory strobes.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams for LB/LH/LW/LBU/LHU/SB/SH/SW;
  - the `lsu_state_t` enum;
  - function `is_aligned(fun3, addr[1:0])`.
- Sub-module `lsu_load_extend`: combinational; takes the raw 32-bit data, fun3 and byte offset; produces the extended `resp_rdata`. Used in the RESP path.

## Test plan
- SW to 0x0 with 0xAABBCCDD, then LW 0x0 → one write cycle (`mem_fun3`=010); response 2 cycles after acceptance; `resp_rdata`=0xAABBCCDD, `resp_err`=0.
- With memory word 0x0 = 0x0000_80FF:
  - LB 0x0 → 0xFFFFFFFF;
  - LBU 0x0 → 0x000000FF;
  - LH 0x0 → 0xFFFF80FF;
  - LHU 0x0 → 0x000080FF.
- `LSU_MISALIGN_EN`, SW 0x1 with 0x11223344 → four SB cycles to addresses 1,2,3,4 with data 0x44,0x33,0x22,0x11; then LW 0x1 → 0x11223344 after 5-cycle latency.
- Without `LSU_MISALIGN_EN`, LH 0x3 → `resp_err`=1 one cycle after acceptance; `mem_read` never asserted.
- Illegal load funct3 011 → `resp_err`=1, no strobes; the next request is accepted normally.
- Reset asserted during split byte k=2 of a word store → all outputs 0 immediately; bytes 0–1 written, bytes 2–3 unchanged; no `resp_valid`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, decode helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_SPLIT,
        ST_RESP
    } lsu_state_t;

    // Access size lives in fun3[1:0] for both signed and unsigned loads.
    function automatic logic is_aligned(input logic [2:0] fun3, input logic [1:0] addr_lo);
        case (fun3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~addr_lo[0];
            2'b10:   return (addr_lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic write, input logic [2:0] fun3);
        if (write)
            return (fun3 == F3_SB) || (fun3 == F3_SH) || (fun3 == F3_SW);
        else
            return (fun3 == F3_LB) || (fun3 == F3_LH) || (fun3 == F3_LW) ||
                   (fun3 == F3_LBU) || (fun3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data extender: selects the addressed lane and sign/zero-extends per funct3.
// Latency: combinational.
// Backpressure: none.
// Ports: raw (32b data), fun3 (load type), byte_off (lane of the datum in raw), ext (result).
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  fun3,
    input  logic [1:0]  byte_off,
    output logic [31:0] ext
);

    logic [31:0] lane;

    assign lane = raw >> {byte_off, 3'b000};

    always_comb begin
        ext = lane;
        case (fun3)
            F3_LB:   ext = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   ext = {{16{lane[15]}}, lane[15:0]};
            F3_LBU:  ext = {24'h0, lane[7:0]};
            F3_LHU:  ext = {16'h0, lane[15:0]};
            default: ext = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute stage and data_memory; optional misaligned split (macro LSU_MISALIGN_EN).
// Latency: aligned 2 cycles, split N+1 cycles (N = bytes), error 1 cycle.
// Backpressure: req_ready high only in IDLE; requests held by the core until accepted.
// Ports: req_* (core request, valid/ready), resp_* (one-cycle response pulse),
//        mem_* (data_memory strobes/address/fun3/data, mem_rdata combinational during mem_read).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_fun3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_fun3,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              wr_q;
    logic [2:0]        fun3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;
    logic              err_q;
    logic              req_legal;
    logic              req_aligned;
    logic              accept_err;
    logic [31:0]       ext_data;

    assign req_legal   = is_legal(req_write, req_fun3);
    assign req_aligned = is_aligned(req_fun3, req_addr[1:0]);

`ifdef LSU_MISALIGN_EN
    logic [1:0]  k_q;
    logic        last_byte;
    logic [31:0] asm_data;

    assign accept_err = ~req_legal;
    // Halves use bytes 0..1, words 0..3; fun3[1] distinguishes the two.
    assign last_byte  = (k_q == (fun3_q[1] ? 2'd3 : 2'd1));

    always_comb begin
        asm_data = data_q;
        asm_data[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
    end
`else
    assign accept_err = ~req_legal | ~req_aligned;
`endif

    // data_memory returns right-aligned data and split loads assemble from lane 0,
    // so the stored datum always starts at byte 0.
    lsu_load_extend u_ext (
        .raw      (data_q),
        .fun3     (fun3_q),
        .byte_off (2'b00),
        .ext      (ext_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_fun3   = 3'b000;
        mem_wdata  = 32'h0;
        case (state_q)
            ST_IDLE: begin
                // Held low while reset is asserted so all outputs read 0.
                req_ready = reset_n;
                if (req_valid) begin
                    if (accept_err)       state_d = ST_RESP;
`ifdef LSU_MISALIGN_EN
                    else if (req_aligned) state_d = ST_ACCESS;
                    else                  state_d = ST_SPLIT;
`else
                    else                  state_d = ST_ACCESS;
`endif
                end
            end
            ST_ACCESS: begin
                mem_read  = ~wr_q;
                mem_write = wr_q;
                mem_addr  = addr_q;
                mem_fun3  = fun3_q;
                mem_wdata = wdata_q;
                state_d   = ST_RESP;
            end
`ifdef LSU_MISALIGN_EN
            ST_SPLIT: begin
                mem_read  = ~wr_q;
                mem_write = wr_q;
                mem_addr  = addr_q + ADDR_W'(k_q);
                mem_fun3  = wr_q ? F3_SB : F3_LBU;
                mem_wdata = {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
                if (last_byte) state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (wr_q || err_q) ? 32'h0 : ext_data;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= 1'b0;
            fun3_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_EN
            k_q     <= 2'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        fun3_q  <= req_fun3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        data_q  <= 32'h0;
                        err_q   <= accept_err;
`ifdef LSU_MISALIGN_EN
                        k_q     <= 2'd0;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (!wr_q) data_q <= mem_rdata;
                end
`ifdef LSU_MISALIGN_EN
                ST_SPLIT: begin
                    k_q <= k_q + 2'd1;
                    if (!wr_q) data_q <= asm_data;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory model.
// Latency: checks response cycle counts per transaction type.
// Backpressure: checks req_ready low while a transaction is in flight.
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_fun3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [2:0]  mem_fun3;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int rd_total = 0;
    int wr_total = 0;
    int rv_total = 0;
    int both_cnt = 0;

    logic [7:0]  mem [0:255];
    logic [7:0]  a0;
    logic [31:0] wl_a[$];
    logic [31:0] wl_d[$];
    logic [2:0]  wl_f[$];

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_fun3   (req_fun3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_fun3   (mem_fun3),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory read: right-aligned, zero-filled; garbage when not strobed.
    always_comb begin
        a0 = mem_addr[7:0];
        if (!mem_read)
            mem_rdata = 32'hDEADBEEF;
        else if (mem_fun3[1:0] == 2'b00)
            mem_rdata = {24'h0, mem[a0]};
        else if (mem_fun3[1:0] == 2'b01)
            mem_rdata = {16'h0, mem[a0 + 8'd1], mem[a0]};
        else
            mem_rdata = {mem[a0 + 8'd3], mem[a0 + 8'd2], mem[a0 + 8'd1], mem[a0]};
    end

    always @(posedge clk) begin
        if (mem_write) begin
            wl_a.push_back(mem_addr);
            wl_d.push_back(mem_wdata);
            wl_f.push_back(mem_fun3);
            mem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_fun3[1:0] != 2'b00) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            if (mem_fun3[1:0] == 2'b10) begin
                mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
            end
        end
        if (mem_read)              rd_total <= rd_total + 1;
        if (mem_write)             wr_total <= wr_total + 1;
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
        if (resp_valid)            rv_total <= rv_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wl_a.delete();
        wl_d.delete();
        wl_f.delete();
    endtask

    task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int e_lat, input logic [31:0] e_rd, input logic e_err,
                       input int e_nrd, input int e_nwr);
        int lat;
        int r0;
        int w0;
        @(negedge clk);
        chk({tag, "/ready"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "/no_resp_idle"}, {31'h0, resp_valid}, 32'h0);
        r0 = rd_total;
        w0 = wr_total;
        req_valid = 1'b1;
        req_write = w;
        req_fun3  = f3;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "/busy"}, {31'h0, req_ready}, 32'h0);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(e_lat));
        chk({tag, "/rdata"}, resp_rdata, e_rd);
        chk({tag, "/err"}, {31'h0, resp_err}, {31'h0, e_err});
        chk({tag, "/reads"}, 32'(rd_total - r0), 32'(e_nrd));
        chk({tag, "/writes"}, 32'(wr_total - w0), 32'(e_nwr));
    endtask

    initial begin
        logic [7:0] eb [4];
        int rv0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_fun3  = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst/ready", {31'h0, req_ready}, 32'h0);
        chk("rst/resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst/mem_read", {31'h0, mem_read}, 32'h0);
        chk("rst/mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst/mem_addr", mem_addr, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("rst/ready_after", {31'h0, req_ready}, 32'h1);

        // Aligned word store then load
        clear_log();
        txn("sw0", 1'b1, 3'b010, 32'h0, 32'hAABBCCDD, 2, 32'h0, 1'b0, 0, 1);
        chk("sw0/log_n", 32'(wl_a.size()), 32'd1);
        if (wl_a.size() == 1) begin
            chk("sw0/log_addr", wl_a[0], 32'h0);
            chk("sw0/log_fun3", {29'h0, wl_f[0]}, 32'h2);
            chk("sw0/log_data", wl_d[0], 32'hAABBCCDD);
        end
        txn("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 2, 32'hAABBCCDD, 1'b0, 1, 0);

        // Extension of byte/half loads
        txn("sw_80ff", 1'b1, 3'b010, 32'h0, 32'h000080FF, 2, 32'h0, 1'b0, 0, 1);
        txn("lb0",  1'b0, 3'b000, 32'h0, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 1, 0);
        txn("lbu0", 1'b0, 3'b100, 32'h0, 32'h0, 2, 32'h000000FF, 1'b0, 1, 0);
        txn("lh0",  1'b0, 3'b001, 32'h0, 32'h0, 2, 32'hFFFF80FF, 1'b0, 1, 0);
        txn("lhu0", 1'b0, 3'b101, 32'h0, 32'h0, 2, 32'h000080FF, 1'b0, 1, 0);
        txn("lb1",  1'b0, 3'b000, 32'h1, 32'h0, 2, 32'hFFFFFF80, 1'b0, 1, 0);

        // Misaligned accesses
`ifdef LSU_MISALIGN_EN
        clear_log();
        txn("sw1", 1'b1, 3'b010, 32'h1, 32'h11223344, 5, 32'h0, 1'b0, 0, 4);
        eb[0] = 8'h44; eb[1] = 8'h33; eb[2] = 8'h22; eb[3] = 8'h11;
        chk("sw1/log_n", 32'(wl_a.size()), 32'd4);
        if (wl_a.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("sw1/addr%0d", i), wl_a[i], 32'(i + 1));
                chk($sformatf("sw1/data%0d", i), wl_d[i], {24'h0, eb[i]});
                chk($sformatf("sw1/fun3%0d", i), {29'h0, wl_f[i]}, 32'h0);
            end
        end
        txn("lw1", 1'b0, 3'b010, 32'h1, 32'h0, 5, 32'h11223344, 1'b0, 4, 0);
        txn("lh3", 1'b0, 3'b001, 32'h3, 32'h0, 3, 32'h00001122, 1'b0, 2, 0);
`else
        txn("sw1", 1'b1, 3'b010, 32'h1, 32'h11223344, 1, 32'h0, 1'b1, 0, 0);
        txn("lh3", 1'b0, 3'b001, 32'h3, 32'h0, 1, 32'h0, 1'b1, 0, 0);
`endif

        // Illegal funct3, then a normal request
        txn("ld011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        txn("ld111", 1'b0, 3'b111, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        txn("st100", 1'b1, 3'b100, 32'h0, 32'h12345678, 1, 32'h0, 1'b1, 0, 0);
`ifdef LSU_MISALIGN_EN
        txn("lw0_after", 1'b0, 3'b010, 32'h0, 32'h0, 2, 32'h223344FF, 1'b0, 1, 0);
`else
        txn("lw0_after", 1'b0, 3'b010, 32'h0, 32'h0, 2, 32'h000080FF, 1'b0, 1, 0);
`endif

        // Reset in the middle of a store
        txn("sw8", 1'b1, 3'b010, 32'h8, 32'h0, 2, 32'h0, 1'b0, 0, 1);
        txn("swc", 1'b1, 3'b010, 32'hC, 32'h0, 2, 32'h0, 1'b0, 0, 1);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_fun3  = 3'b010;
`ifdef LSU_MISALIGN_EN
        req_addr  = 32'h9;
        req_wdata = 32'hA1B2C3D4;
`else
        req_addr  = 32'h8;
        req_wdata = 32'h55555555;
`endif
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
`ifdef LSU_MISALIGN_EN
        repeat (2) @(negedge clk);
        chk("abort/k2_addr", mem_addr, 32'hB);
        chk("abort/k2_data", mem_wdata, 32'h000000B2);
`endif
        chk("abort/pre_write", {31'h0, mem_write}, 32'h1);
        rv0 = rv_total;
        reset_n = 1'b0;
        #1;
        chk("abort/mem_write", {31'h0, mem_write}, 32'h0);
        chk("abort/mem_addr", mem_addr, 32'h0);
        chk("abort/mem_wdata", mem_wdata, 32'h0);
        chk("abort/mem_fun3", {29'h0, mem_fun3}, 32'h0);
        chk("abort/ready", {31'h0, req_ready}, 32'h0);
        chk("abort/resp_valid", {31'h0, resp_valid}, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort/no_resp", 32'(rv_total - rv0), 32'h0);
`ifdef LSU_MISALIGN_EN
        txn("lw8_after", 1'b0, 3'b010, 32'h8, 32'h0, 2, 32'h00C3D400, 1'b0, 1, 0);
`else
        txn("lw8_after", 1'b0, 3'b010, 32'h8, 32'h0, 2, 32'h00000000, 1'b0, 1, 0);
`endif
        txn("lwc_after", 1'b0, 3'b010, 32'hC, 32'h0, 2, 32'h00000000, 1'b0, 1, 0);

        @(negedge clk);
        chk("strobes_exclusive", 32'(both_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
